// File: rtl/receiver.sv
// UART receive stage: oversampled start detection, LSB-first data, even parity, one stop bit.
// Optional URX_SYNC_EN adds a 2-flop synchronizer on rx_data. WIDTH must be >= 2.
module receiver #(
  parameter int WIDTH = 8,
  parameter int OVS   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             rx_data,
  input  logic             d_ack,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             rx_bz,
  output logic [2:0]       state_dbg
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic             rx_s;
  logic             prev_s;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;

  assign state_dbg = state;

`ifdef URX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_data};
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_data;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      prev_s     <= 1'b1;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      d_out      <= '0;
      d_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      rx_bz      <= 1'b0;
    end else begin
      // The acknowledge is not gated by en; a completing frame below overrides it.
      if (d_ack && d_valid) begin
        d_valid    <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      if (en) begin
        prev_s <= rx_s;
        case (state)
          IDLE: begin
            if (prev_s && !rx_s) begin
              state    <= START;
              rx_bz    <= 1'b1;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                rx_bz <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[WIDTH-1:1]};
              if (bit_cnt == DATA_LAST) state <= PARITY;
              else                      bit_cnt <= bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          PARITY: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt   <= '0;
              state      <= IDLE;
              rx_bz      <= 1'b0;
              d_out      <= shreg;
              parity_err <= par_bit ^ (^shreg);
              frame_err  <= ~rx_s;
              d_valid    <= 1'b1;
              overrun    <= d_valid & ~d_ack;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rx_bz <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: frames are pushed to an expected queue when driven and popped
// when the receiver completes a frame; direct checks cover reset, glitch and break cases.
module tb_receiver;
  localparam int WIDTH = 8;
  localparam int OVS   = 16;

  logic             clk;
  logic             rstn;
  logic             en;
  logic             rx_data;
  logic             d_ack;
  logic [WIDTH-1:0] d_out;
  logic             d_valid;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic             rx_bz;
  logic [2:0]       state_dbg;

  receiver #(.WIDTH(WIDTH), .OVS(OVS)) dut (
    .clk(clk), .rstn(rstn), .en(en), .rx_data(rx_data), .d_ack(d_ack),
    .d_out(d_out), .d_valid(d_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_bz(rx_bz),
    .state_dbg(state_dbg)
  );

  // clock / reset / enable
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic en_half;
  initial begin
    en = 1'b1;
    forever begin
      @(negedge clk);
      en = en_half ? ~en : 1'b1;
    end
  end

  // scoreboard: {overrun, parity_err, frame_err, data}
  logic [WIDTH+2:0] exp_q[$];
  int n_checks;
  int n_fail;
  logic model_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic rx_bz_q;
  logic [WIDTH+2:0] item;
  always @(negedge clk) begin
    if (rx_bz_q && !rx_bz && d_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {21'd0, overrun, parity_err, frame_err, d_out}, 32'hFFFF_FFFF);
      end else begin
        item = exp_q.pop_front();
        check("frame", {21'd0, overrun, parity_err, frame_err, d_out}, {21'd0, item});
      end
    end
    rx_bz_q <= rx_bz;
  end

  // driver tasks
  task automatic hold_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (en) c++;
    end
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_data = b;
    hold_ticks(OVS);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input logic pflip, input logic stop);
    exp_q.push_back({model_valid, pflip, ~stop, data});
    model_valid = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) drive_bit(data[i]);
    drive_bit((^data) ^ pflip);
    drive_bit(stop);
  endtask

  task automatic ack();
    @(negedge clk);
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    model_valid = 1'b0;
    check("ack_valid", {31'd0, d_valid}, 32'd0);
    check("ack_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
  endtask

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_mid_frame(input logic [WIDTH-1:0] data);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(data[i]);
    rx_data = data[3];
    hold_ticks(OVS / 2);
    rstn = 1'b0;
    #1;
    check("rst_dout", {24'd0, d_out}, 32'd0);
    check("rst_flags", {27'd0, d_valid, parity_err, frame_err, overrun, rx_bz}, 32'd0);
    model_valid = 1'b0;
    rx_data = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(8);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(4);
    check("after_rst_dout", {24'd0, d_out}, 32'h7E);
    check("after_rst_valid", {31'd0, d_valid}, 32'd1);
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    model_valid = 1'b0;
    en_half = 1'b0;
    rstn = 1'b0;
    rx_data = 1'b1;
    d_ack = 1'b0;
    rx_bz_q = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", {24'd0, d_out}, 32'd0);
    check("reset_flags", {27'd0, d_valid, parity_err, frame_err, overrun, rx_bz}, 32'd0);
    rstn = 1'b1;
    idle(5);

    // clean frame, then acknowledge
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(4);
    check("5a_dout", {24'd0, d_out}, 32'h5A);
    check("5a_status", {29'd0, d_valid, parity_err, frame_err}, 32'b100);
    ack();

    // parity error
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);
    check("a5_status", {21'd0, d_valid, parity_err, frame_err, d_out}, {21'd0, 3'b110, 8'hA5});
    ack();

    // framing error followed by a long break
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("brk_ferr", {30'd0, d_valid, frame_err}, 32'b11);
    check("brk_idle", {31'd0, rx_bz}, 32'd0);
    ack();
    idle(6);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(4);
    check("post_brk", {21'd0, d_valid, parity_err, frame_err, d_out}, {21'd0, 3'b100, 8'h01});
    ack();

    // short low glitch: false start
    idle(4);
    rx_data = 1'b0;
    repeat (4) @(negedge clk);
    rx_data = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", {31'd0, rx_bz}, 32'd1);
    repeat (20) @(negedge clk);
    check("glitch_done", {30'd0, rx_bz, d_valid}, 32'd0);

    // overrun: two frames without acknowledge
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(4);
    check("ovr_state", {21'd0, d_valid, overrun, parity_err, d_out}, {21'd0, 3'b110, 8'h22});
    ack();

    // reset mid-frame, at full rate and with en toggling
    reset_mid_frame(8'h7E);
    en_half = 1'b1;
    idle(4);
    reset_mid_frame(8'h7E);
    en_half = 1'b0;
    idle(8);

    // random frames
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      idle(4);
      ack();
    end

    idle(8);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
